// File: rtl/iq_unpack_8to32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iq_unpack_8to32: expands each packed 4x8-bit IQ word into four {I16,Q16}  |
// | samples. Define IQ_UNPACK_ROUND_EN for a half-step low-bit offset.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module iq_unpack_8to32 #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

`ifdef IQ_UNPACK_ROUND_EN
  localparam logic [8:0] C_LOW_BITS = 9'h100;
`else
  localparam logic [8:0] C_LOW_BITS = 9'h000;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_beat, w_beat_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic        r_last, w_last_nxt;

  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_i16, w_q16;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_hold  <= 32'h0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    i_tready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          w_hold_nxt  = i_tdata;
          w_last_nxt  = i_tlast;
          w_beat_nxt  = 2'd0;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        // Input is only taken on the final beat so the next word follows with no bubble.
        i_tready = (r_beat == 2'd3) && o_tready;
        if (o_tready) begin
          if (r_beat == 2'd3) begin
            w_beat_nxt = 2'd0;
            if (i_tvalid) begin
              w_hold_nxt = i_tdata;
              w_last_nxt = i_tlast;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_beat_nxt = r_beat + 2'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_lane  = (MSB_FIRST != 0) ? (2'd3 - r_beat) : r_beat;
  assign w_byte  = r_hold[{w_lane, 3'b000} +: 8];
  assign w_i16   = {{4{w_byte[7]}}, w_byte[6:4], C_LOW_BITS};
  assign w_q16   = {{4{w_byte[3]}}, w_byte[2:0], C_LOW_BITS};

  // Data is forced to zero while idle so the rounding offset never shows on an invalid bus.
  assign o_tvalid = (r_state == S_EMIT);
  assign o_tlast  = o_tvalid && r_last && (r_beat == 2'd3);
  assign o_tdata  = o_tvalid ? {w_i16, w_q16} : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_iq_unpack_8to32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iq_unpack_8to32: directed self-checking bench for iq_unpack_8to32.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_iq_unpack_8to32;

`ifdef IQ_UNPACK_ROUND_EN
  localparam logic [31:0] RND = 32'h0100_0100;
`else
  localparam logic [31:0] RND = 32'h0000_0000;
`endif

  localparam logic [31:0] W1 = 32'h8F70_11FF;
  localparam logic [31:0] W2 = 32'h7F80_0108;
  localparam logic [31:0] W3 = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready, i_tready_l;
  logic [31:0] o_tdata, o_tdata_l;
  logic        o_tlast, o_tlast_l;
  logic        o_tvalid, o_tvalid_l;
  logic        o_tready;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_w1 [4]  = '{32'hF000FE00, 32'h0E000000, 32'h02000200, 32'hFE00FE00};
  logic [31:0] exp_seq [12] = '{32'hF000FE00, 32'h0E000000, 32'h02000200, 32'hFE00FE00,
                                32'h0E00FE00, 32'hF0000000, 32'h00000200, 32'h0000F000,
                                32'h02000400, 32'h06000800, 32'h0A000C00, 32'h0E00F000};
  logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int          bt  [8] = '{0, 1, 1, 1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  iq_unpack_8to32 #(.MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  iq_unpack_8to32 #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready_l),
    .o_tdata(o_tdata_l), .o_tlast(o_tlast_l), .o_tvalid(o_tvalid_l), .o_tready(o_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    reset    = 1'b1;
    i_tvalid = 1'b0;
    i_tdata  = 32'h0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_tvalid", {31'b0, o_tvalid}, 32'd0);
    chk("rst_tlast",  {31'b0, o_tlast},  32'd0);
    chk("rst_tdata",  o_tdata,           32'h0);
    chk("rst_itready", {31'b0, i_tready}, 32'd1);
    next_cycle();

    // Single word, both lane orders
    i_tvalid = 1'b1; i_tdata = W1; i_tlast = 1'b0;
    #1 chk("t1_accept", {31'b0, i_tready}, 32'd1);
    next_cycle();
    i_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t1_tvalid", {31'b0, o_tvalid}, 32'd1);
      chk("t1_msb_data", o_tdata, exp_w1[k] | RND);
      chk("t1_lsb_data", o_tdata_l, exp_w1[3-k] | RND);
      chk("t1_itready", {31'b0, i_tready}, (k == 3) ? 32'd1 : 32'd0);
      chk("t1_tlast", {31'b0, o_tlast}, 32'd0);
      next_cycle();
    end
    #1 chk("t1_idle", {31'b0, o_tvalid}, 32'd0);

    // Three back-to-back words, tlast on the third
    i_tvalid = 1'b1; i_tdata = W1; i_tlast = 1'b0;
    next_cycle();
    for (int k = 0; k < 12; k++) begin
      if (k < 4) begin
        i_tvalid = 1'b1; i_tdata = W2; i_tlast = 1'b0;
      end else if (k < 8) begin
        i_tvalid = 1'b1; i_tdata = W3; i_tlast = 1'b1;
      end else begin
        i_tvalid = 1'b0; i_tlast = 1'b0;
      end
      #1;
      chk("t2_tvalid", {31'b0, o_tvalid}, 32'd1);
      chk("t2_data", o_tdata, exp_seq[k] | RND);
      chk("t2_tlast", {31'b0, o_tlast}, (k == 11) ? 32'd1 : 32'd0);
      chk("t2_itready", {31'b0, i_tready}, (k % 4 == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    #1 chk("t2_idle", {31'b0, o_tvalid}, 32'd0);

    // Backpressure with a 1,0,0,1 ready pattern
    i_tvalid = 1'b1; i_tdata = W1; i_tlast = 1'b1;
    next_cycle();
    i_tvalid = 1'b0; i_tlast = 1'b0;
    hs = 0;
    for (int j = 0; j < 8; j++) begin
      o_tready = rdy[j];
      #1;
      chk("t3_tvalid", {31'b0, o_tvalid}, 32'd1);
      chk("t3_data", o_tdata, exp_w1[bt[j]] | RND);
      chk("t3_tlast", {31'b0, o_tlast}, (bt[j] == 3) ? 32'd1 : 32'd0);
      chk("t3_itready", {31'b0, i_tready}, (bt[j] == 3 && rdy[j]) ? 32'd1 : 32'd0);
      if (o_tvalid && o_tready) hs++;
      next_cycle();
    end
    o_tready = 1'b1;
    #1;
    chk("t3_idle", {31'b0, o_tvalid}, 32'd0);
    chk("t3_handshakes", hs, 32'd4);

    // Asynchronous reset in the middle of a word
    i_tvalid = 1'b1; i_tdata = W1; i_tlast = 1'b0;
    next_cycle();
    i_tvalid = 1'b0;
    next_cycle();
    next_cycle();
    #1 chk("t4_beat2_data", o_tdata, exp_w1[2] | RND);
    reset = 1'b1;
    #1;
    chk("t4_rst_tvalid", {31'b0, o_tvalid}, 32'd0);
    chk("t4_rst_tdata", o_tdata, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("t4_post_itready", {31'b0, i_tready}, 32'd1);
    chk("t4_post_tvalid", {31'b0, o_tvalid}, 32'd0);
    i_tvalid = 1'b1; i_tdata = 32'h0; i_tlast = 1'b0;
    next_cycle();
    i_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_tvalid", {31'b0, o_tvalid}, 32'd1);
      chk("t4_data", o_tdata, 32'h0 | RND);
      next_cycle();
    end
    #1 chk("t4_idle", {31'b0, o_tvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iq_unpack_8to32.md
IQ_UNPACK_8TO32 -- requirements
Module: iq_unpack_8to32

Interface
REQ-001 Parameter MSB_FIRST, default 1, lane order: 1 = byte [31:24] emitted first, 0 = byte [7:0] emitted first.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_tdata  input  32  packed word of four 8-bit IQ codes {I_sign, I[2:0], Q_sign, Q[2:0]}.
REQ-005 i_tlast  input  1  end of packet on the packed stream.
REQ-006 i_tvalid  input  1  packed word valid.
REQ-007 i_tready  output  1  block accepts i_tdata this cycle.
REQ-008 o_tdata  output  32  expanded sample {I16, Q16}.
REQ-009 o_tlast  output  1  end of packet on the expanded stream.
REQ-010 o_tvalid  output  1  expanded sample valid.
REQ-011 o_tready  input  1  downstream accepts o_tdata.

Function
REQ-012 State machine: IDLE (no word held) and EMIT (word held, beat counter 0..3).
REQ-013 IDLE: i_tready = 1, o_tvalid = 0; on i_tvalid, capture i_tdata and i_tlast into hold registers, beat <= 0, go to EMIT.
REQ-014 EMIT: o_tvalid = 1; beat advances only on o_tvalid & o_tready; o_tdata/o_tlast stable while o_tready = 0.
REQ-015 Latency: first expanded sample valid one cycle after input acceptance.
REQ-016 Lane select: beat k selects byte k counted from [31:24] when MSB_FIRST = 1, from [7:0] when MSB_FIRST = 0.
REQ-017 Expansion of byte b: I16 = {4{b[7]}, b[6:4], 9'b0}; Q16 = {4{b[3]}, b[2:0], 9'b0}; o_tdata = {I16, Q16}.
REQ-018 i_tready in EMIT = (beat == 3) & o_tready; no other cycle of EMIT accepts input.
REQ-019 Beat 3 accepted with i_tvalid = 1: load new word, beat <= 0, stay EMIT (gap-free, 4 outputs per input at full rate).
REQ-020 Beat 3 accepted with i_tvalid = 0: go to IDLE.
REQ-021 o_tlast = held tlast & (beat == 3); beats 0..2 always o_tlast = 0.
REQ-022 Input word count is not constrained; packets of one packed word produce four outputs with tlast on the fourth.
REQ-023 Block never drops or duplicates a sample; each accepted word yields exactly four output handshakes.

Reset
REQ-024 Reset: state IDLE, beat 0, hold data 32'h0, held tlast 0; o_tvalid = 0, o_tlast = 0, o_tdata = 32'h0, i_tready = 1 after reset deasserts.
REQ-025 Reset mid-EMIT discards the held word and any remaining beats immediately (asynchronous).

Configuration
REQ-026 Macro IQ_UNPACK_ROUND_EN defined: I16 and Q16 low 9 bits = 9'h100 (half-step reconstruction offset) instead of 9'h000.
REQ-027 Macro undefined: low 9 bits = 9'h000 exactly per REQ-017; no other behaviour differs.

Verification
REQ-028 MSB_FIRST=1, i_tdata=0x8F7011FF, o_tready=1 -> o_tdata 0xF000FE00, 0x0E000000, 0x02000200, 0xFE00FE00 on four consecutive cycles.
REQ-029 Same word with IQ_UNPACK_ROUND_EN -> 0xF100FF00, 0x0F000100, 0x03000300, 0xFF00FF00.
REQ-030 MSB_FIRST=0, same word -> 0xFE00FE00, 0x02000200, 0x0E000000, 0xF000FE00.
REQ-031 Back-to-back 3 words, last with i_tlast=1, o_tready=1 -> 12 outputs with no bubble, o_tlast only on output 12, i_tready high only on outputs 4 and 8 and 12.
REQ-032 o_tready toggled 1,0,0,1 pattern during EMIT -> o_tdata held stable while stalled, exactly 4 handshakes, i_tready low until beat 3 handshake.
REQ-033 Reset asserted after beat 1 of 0x8F7011FF -> o_tvalid 0 at once; after release, new word 0x00000000 yields four 0x00000000 outputs, none from the old word.
